// File: rtl/apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_arb_master
// Purpose  : two-requester round-robin arbiter in front of one APB master port
// Revision : 1.0  initial release
// ============================================================================
module apb_arb_master #(
   parameter int TIMEOUT = 16
) (
   input  logic        pclk,
   input  logic        preset,

   input  logic        req_valid_0,
   output logic        req_ready_0,
   input  logic [11:0] req_addr_0,
   input  logic        req_write_0,
   input  logic [31:0] req_wdata_0,
   input  logic [3:0]  req_strb_0,
   output logic        rsp_valid_0,
   output logic [31:0] rsp_rdata_0,
   output logic        rsp_err_0,

   input  logic        req_valid_1,
   output logic        req_ready_1,
   input  logic [11:0] req_addr_1,
   input  logic        req_write_1,
   input  logic [31:0] req_wdata_1,
   input  logic [3:0]  req_strb_1,
   output logic        rsp_valid_1,
   output logic [31:0] rsp_rdata_1,
   output logic        rsp_err_1,

   output logic [11:0] paddr,
   output logic        psel,
   output logic        penable,
   output logic        pwrite,
   output logic [3:0]  pstrb,
   output logic [31:0] pwdata,
   input  logic [31:0] prdata,
   input  logic        pready,
   input  logic        pslverr
);

   localparam int c_CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               r_last_grant;
   logic               r_owner;
   logic [c_CNT_W-1:0] r_wait_cnt;

   logic               w_grant;
   logic               w_any_valid;
   logic               w_accept;
   logic               w_done;
   logic               w_abort;
   logic               w_wait_hit;
   logic [11:0]        w_sel_addr;
   logic               w_sel_write;
   logic [31:0]        w_sel_wdata;
   logic [3:0]         w_sel_strb;
   logic [31:0]        w_rsp_data;

   // On a tie the requester that did not win last time gets the bus.
   assign w_any_valid = req_valid_0 | req_valid_1;
   assign w_grant     = (req_valid_0 & req_valid_1) ? ~r_last_grant : req_valid_1;

   assign w_sel_addr  = w_grant ? req_addr_1  : req_addr_0;
   assign w_sel_write = w_grant ? req_write_1 : req_write_0;
   assign w_sel_wdata = w_grant ? req_wdata_1 : req_wdata_0;
   assign w_sel_strb  = w_grant ? req_strb_1  : req_strb_0;

   // Current stall cycle would be the TIMEOUT-th consecutive one without pready.
   assign w_wait_hit  = (TIMEOUT != 0) && ((int'(r_wait_cnt) + 1) == TIMEOUT);

   assign w_rsp_data  = (w_abort | pwrite) ? 32'h0 : prdata;

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      psel        = 1'b0;
      penable     = 1'b0;
      req_ready_0 = 1'b0;
      req_ready_1 = 1'b0;
      w_accept    = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!preset) begin
               req_ready_0 = req_valid_0 & ~w_grant;
               req_ready_1 = req_valid_1 &  w_grant;
               if (w_any_valid) begin
                  w_accept    = 1'b1;
                  w_state_nxt = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            psel        = 1'b1;
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready) begin
               w_done      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (w_wait_hit) begin
               w_abort     = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Request capture, arbitration pointer and stall counter.
   always_ff @(posedge pclk) begin
      if (preset) begin
         r_last_grant <= 1'b1;
         r_owner      <= 1'b0;
         paddr        <= 12'h0;
         pwrite       <= 1'b0;
         pwdata       <= 32'h0;
         pstrb        <= 4'h0;
         r_wait_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_last_grant <= w_grant;
            r_owner      <= w_grant;
            paddr        <= w_sel_addr;
            pwrite       <= w_sel_write;
            pwdata       <= w_sel_wdata;
            pstrb        <= w_sel_write ? w_sel_strb : 4'h0;
         end
         if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
         end else if ((r_state == ST_ACCESS) && !pready) begin
            r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
         end
      end
   end

   // Response data is held per requester until its next completion.
   always_ff @(posedge pclk) begin
      if (preset) begin
         rsp_valid_0 <= 1'b0;
         rsp_rdata_0 <= 32'h0;
         rsp_err_0   <= 1'b0;
         rsp_valid_1 <= 1'b0;
         rsp_rdata_1 <= 32'h0;
         rsp_err_1   <= 1'b0;
      end else begin
         rsp_valid_0 <= 1'b0;
         rsp_valid_1 <= 1'b0;
         if (w_done | w_abort) begin
            if (r_owner) begin
               rsp_valid_1 <= 1'b1;
               rsp_rdata_1 <= w_rsp_data;
               rsp_err_1   <= w_abort | pslverr;
            end else begin
               rsp_valid_0 <= 1'b1;
               rsp_rdata_0 <= w_rsp_data;
               rsp_err_0   <= w_abort | pslverr;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_apb_arb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_arb_master
// Purpose  : directed and randomized checks of apb_arb_master vs a transfer model
// Revision : 1.0  initial release
// ============================================================================
module tb_apb_arb_master;

   localparam int TO = 4;

   logic        pclk   = 1'b0;
   logic        preset = 1'b1;
   logic        req_valid [2];
   logic        req_ready [2];
   logic [11:0] req_addr  [2];
   logic        req_write [2];
   logic [31:0] req_wdata [2];
   logic [3:0]  req_strb  [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic [11:0] paddr;
   logic        psel, penable, pwrite;
   logic [3:0]  pstrb;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready, pslverr;

   int vectors     = 0;
   int miscompares = 0;

   apb_arb_master #(.TIMEOUT(TO)) dut (
      .pclk        (pclk),
      .preset      (preset),
      .req_valid_0 (req_valid[0]),
      .req_ready_0 (req_ready[0]),
      .req_addr_0  (req_addr[0]),
      .req_write_0 (req_write[0]),
      .req_wdata_0 (req_wdata[0]),
      .req_strb_0  (req_strb[0]),
      .rsp_valid_0 (rsp_valid[0]),
      .rsp_rdata_0 (rsp_rdata[0]),
      .rsp_err_0   (rsp_err[0]),
      .req_valid_1 (req_valid[1]),
      .req_ready_1 (req_ready[1]),
      .req_addr_1  (req_addr[1]),
      .req_write_1 (req_write[1]),
      .req_wdata_1 (req_wdata[1]),
      .req_strb_1  (req_strb[1]),
      .rsp_valid_1 (rsp_valid[1]),
      .rsp_rdata_1 (rsp_rdata[1]),
      .rsp_err_1   (rsp_err[1]),
      .paddr       (paddr),
      .psel        (psel),
      .penable     (penable),
      .pwrite      (pwrite),
      .pstrb       (pstrb),
      .pwdata      (pwdata),
      .prdata      (prdata),
      .pready      (pready),
      .pslverr     (pslverr)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transfer-level model: m_busy with m_cyc counting cycles since the accept.
   logic        m_busy   = 1'b0;
   int          m_cyc    = 0;
   int          m_stall  = 0;
   logic        m_owner  = 1'b0;
   logic        m_last   = 1'b1;
   logic [11:0] m_paddr  = 12'h0;
   logic        m_pwrite = 1'b0;
   logic [31:0] m_pwdata = 32'h0;
   logic [3:0]  m_pstrb  = 4'h0;
   logic        m_pulse [2] = '{1'b0, 1'b0};
   logic [31:0] m_rdata [2] = '{32'h0, 32'h0};
   logic        m_err   [2] = '{1'b0, 1'b0};

   function automatic logic m_grant();
      return (req_valid[0] && req_valid[1]) ? !m_last : req_valid[1];
   endfunction

   task automatic m_finish(input logic o, input logic e, input logic [31:0] d);
      m_pulse[o] = 1'b1;
      m_err[o]   = e;
      m_rdata[o] = d;
      m_busy     = 1'b0;
   endtask

   task automatic m_step();
      logic g;
      if (preset) begin
         m_busy = 1'b0; m_last = 1'b1; m_owner = 1'b0;
         m_paddr = 12'h0; m_pwrite = 1'b0; m_pwdata = 32'h0; m_pstrb = 4'h0;
         for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 1'b0; m_rdata[k] = 32'h0; m_err[k] = 1'b0;
         end
      end else begin
         m_pulse[0] = 1'b0;
         m_pulse[1] = 1'b0;
         if (!m_busy) begin
            if (req_valid[0] || req_valid[1]) begin
               g        = m_grant();
               m_paddr  = req_addr[g];
               m_pwrite = req_write[g];
               m_pwdata = req_wdata[g];
               m_pstrb  = req_write[g] ? req_strb[g] : 4'h0;
               m_busy   = 1'b1;
               m_cyc    = 0;
               m_last   = g;
               m_owner  = g;
            end
         end else if (m_cyc == 0) begin
            m_cyc   = 1;
            m_stall = 0;
         end else if (pready) begin
            m_finish(m_owner, pslverr, m_pwrite ? 32'h0 : prdata);
         end else begin
            m_stall++;
            if (TO != 0 && m_stall == TO) m_finish(m_owner, 1'b1, 32'h0);
            else                          m_cyc++;
         end
      end
   endtask

   // Compare process: every cycle, 4 time units after the edge.
   always begin
      @(posedge pclk);
      #4;
      chk("psel",    psel,    m_busy);
      chk("penable", penable, m_busy && (m_cyc >= 1));
      chk("paddr",   paddr,   m_paddr);
      chk("pwrite",  pwrite,  m_pwrite);
      chk("pwdata",  pwdata,  m_pwdata);
      chk("pstrb",   pstrb,   m_pstrb);
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rsp_valid_%0d", k), rsp_valid[k], m_pulse[k]);
         chk($sformatf("rsp_rdata_%0d", k), rsp_rdata[k], m_rdata[k]);
         chk($sformatf("rsp_err_%0d", k),   rsp_err[k],   m_err[k]);
         chk($sformatf("req_ready_%0d", k), req_ready[k],
             !preset && !m_busy && req_valid[k] && (m_grant() == (k == 1)));
      end
      m_step();
   end

   task automatic step();
      @(posedge pclk);
      #2;
   endtask

   task automatic set_req(input int k, input logic [11:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] s);
      req_valid[k] = 1'b1;
      req_addr[k]  = a;
      req_write[k] = w;
      req_wdata[k] = d;
      req_strb[k]  = s;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, got %0d vectors, want finish", vectors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int owners[$];
      int p_ready;
      for (int k = 0; k < 2; k++) begin
         req_valid[k] = 1'b0; req_addr[k] = 12'h0; req_write[k] = 1'b0;
         req_wdata[k] = 32'h0; req_strb[k] = 4'h0;
      end
      pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;

      // Reset with a request already pending.
      set_req(0, 12'h010, 1'b1, 32'hA5A5_1234, 4'h3);
      step(); step();
      #1;
      chk("reset_ready_0", req_ready[0], 1'b0);
      chk("reset_psel", psel, 1'b0);
      chk("reset_paddr", paddr, 12'h0);
      chk("reset_rsp_rdata_0", rsp_rdata[0], 32'h0);

      // Single write from requester 0.
      preset = 1'b0; pready = 1'b1;
      #1 chk("a_ready_0", req_ready[0], 1'b1);
      step(); req_valid[0] = 1'b0;
      #1;
      chk("a_psel_setup", psel, 1'b1);
      chk("a_penable_setup", penable, 1'b0);
      chk("a_pstrb", pstrb, 4'h3);
      chk("a_paddr", paddr, 12'h010);
      chk("a_pwdata", pwdata, 32'hA5A5_1234);
      step(); #1 chk("a_penable_access", penable, 1'b1);
      step(); #1;
      chk("a_rsp_valid_0", rsp_valid[0], 1'b1);
      chk("a_rsp_err_0", rsp_err[0], 1'b0);
      chk("a_rsp_rdata_0", rsp_rdata[0], 32'h0);
      chk("a_psel_idle", psel, 1'b0);
      step(); #1 chk("a_rsp_pulse_once", rsp_valid[0], 1'b0);

      // Read from requester 1: three stalls, then pready with error (4th cycle wins over timeout).
      step(); pready = 1'b0; set_req(1, 12'h020, 1'b0, 32'h1111_2222, 4'hF);
      #1;
      chk("b_ready_1", req_ready[1], 1'b1);
      chk("b_ready_0", req_ready[0], 1'b0);
      step(); req_valid[1] = 1'b0;
      #1;
      chk("b_pstrb_read", pstrb, 4'h0);
      chk("b_pwrite", pwrite, 1'b0);
      chk("b_paddr", paddr, 12'h020);
      repeat (3) begin
         step(); #1 chk("b_wait_penable", penable, 1'b1);
      end
      step(); pready = 1'b1; prdata = 32'hDEAD_BEEF; pslverr = 1'b1;
      #1 chk("b_access4_penable", penable, 1'b1);
      step(); pready = 1'b0; prdata = 32'h0; pslverr = 1'b0;
      #1;
      chk("b_rsp_valid_1", rsp_valid[1], 1'b1);
      chk("b_rsp_rdata_1", rsp_rdata[1], 32'hDEAD_BEEF);
      chk("b_rsp_err_1", rsp_err[1], 1'b1);
      chk("b_rsp_valid_0", rsp_valid[0], 1'b0);
      step(); #1;
      chk("b_rsp_pulse_once", rsp_valid[1], 1'b0);
      chk("b_rdata_hold", rsp_rdata[1], 32'hDEAD_BEEF);

      // Timeout: pready stays low for four ACCESS cycles.
      step(); prdata = 32'hFFFF_FFFF; set_req(0, 12'h030, 1'b0, 32'h0, 4'h5);
      #1 chk("c_ready_0", req_ready[0], 1'b1);
      step(); req_valid[0] = 1'b0;
      #1 chk("c_pstrb_read", pstrb, 4'h0);
      repeat (4) begin
         step(); #1 chk("c_stall_penable", penable, 1'b1);
      end
      step(); #1;
      chk("c_abort_psel", psel, 1'b0);
      chk("c_abort_penable", penable, 1'b0);
      chk("c_abort_rsp_valid_0", rsp_valid[0], 1'b1);
      chk("c_abort_err_0", rsp_err[0], 1'b1);
      chk("c_abort_rdata_0", rsp_rdata[0], 32'h0);

      // Contention straight after reset: grants alternate starting with requester 0.
      step(); prdata = 32'h0; preset = 1'b1; pready = 1'b1;
      set_req(0, 12'h100, 1'b1, 32'h0000_0100, 4'hF);
      set_req(1, 12'h200, 1'b0, 32'h0, 4'h0);
      step(); preset = 1'b0;
      owners = {};
      for (int i = 0; i < 16 && owners.size() < 4; i++) begin
         step(); #1;
         if (rsp_valid[0]) owners.push_back(0);
         if (rsp_valid[1]) owners.push_back(1);
      end
      chk("d_grant_count", owners.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("d_grant_%0d", i), (i < owners.size()) ? owners[i] : -1, i % 2);

      // Reset during ACCESS after a requester-0 win; the following tie must go to 0.
      req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      repeat (4) step();
      pready = 1'b0; set_req(0, 12'h3C0, 1'b1, 32'hCAFE_F00D, 4'hC);
      step(); req_valid[0] = 1'b0;
      step(); #1 chk("e_penable", penable, 1'b1);
      preset = 1'b1;
      step(); preset = 1'b0;
      #1;
      chk("e_psel_after_reset", psel, 1'b0);
      chk("e_penable_after_reset", penable, 1'b0);
      chk("e_no_rsp_0", rsp_valid[0], 1'b0);
      chk("e_paddr_cleared", paddr, 12'h0);
      set_req(0, 12'h0AA, 1'b1, 32'h1234_5678, 4'hF);
      set_req(1, 12'h0BB, 1'b0, 32'h0, 4'h0);
      #1;
      chk("e_tie_ready_0", req_ready[0], 1'b1);
      chk("e_tie_ready_1", req_ready[1], 1'b0);
      step(); req_valid[0] = 1'b0; req_valid[1] = 1'b0; pready = 1'b1;
      repeat (6) step();

      // Randomized traffic at three slave-latency levels, with rare resets.
      for (int seg = 0; seg < 3; seg++) begin
         p_ready = (seg == 0) ? 70 : (seg == 1) ? 25 : 6;
         repeat (1000) begin
            step();
            preset = ($urandom_range(0, 399) == 0);
            for (int k = 0; k < 2; k++) begin
               req_valid[k] = ($urandom_range(0, 99) < 55);
               req_addr[k]  = 12'($urandom);
               req_write[k] = 1'($urandom);
               req_wdata[k] = $urandom;
               req_strb[k]  = 4'($urandom);
            end
            pready  = ($urandom_range(0, 99) < p_ready);
            pslverr = ($urandom_range(0, 3) == 0);
            prdata  = $urandom;
         end
      end

      step();
      preset = 1'b0; req_valid[0] = 1'b0; req_valid[1] = 1'b0; pready = 1'b1;
      repeat (8) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
